hs_arb_ctrl: RTL and testbench

HS_ARB_CTRL -- requirements
Module: hs_arb_ctrl

---
 rtl/hs_pkg.sv | 31 +++
 rtl/hs_rr_arb.sv | 32 +++
 rtl/hs_arb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hs_arb_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the handshake arbiter controller: FSM state encoding,
// Prog mode constants, default sizing and a one-hot to index helper.
package hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_XFER  = 3'd4,
        ST_DRAIN = 3'd5
    } hs_state_e;

    localparam logic [1:0] PROG_RT       = 2'b00;
    localparam logic [1:0] PROG_BM       = 2'b01;
    localparam logic [1:0] PROG_BOTH_PRI = 2'b10;
    localparam logic [1:0] PROG_BOTH_ALT = 2'b11;

    localparam int HS_NCH_DEF    = 4;
    localparam int HS_TO_CYC_DEF = 16;

    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hs_rr_arb.sv
// Round-robin channel search: first set request at or after ptr, wrapping.
// Purely combinational; the caller registers the result.
module hs_rr_arb #(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic           vld
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
            idx = sum[PW-1:0];
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_arb_ctrl.sv
// Handshake arbiter controller: round-robin grant, two-phase ready handshake,
// one-cycle transfer and drain. Optional wait-state timeout via HS_TIMEOUT_EN.
module hs_arb_ctrl
    import hs_pkg::*;
#(
    parameter int NCH    = HS_NCH_DEF,
    parameter int TO_CYC = HS_TO_CYC_DEF
) (
    input  logic           CK,
    input  logic           RstN,
    input  logic [NCH-1:0] WantRt,
    input  logic [NCH-1:0] WantBm,
    input  logic [NCH-1:0] Rdy1,
    input  logic [NCH-1:0] Rdy2,
    input  logic           FullI,
    input  logic           FullO,
    input  logic           InDone,
    input  logic [1:0]     Prog,
    output logic [NCH-1:0] Grant,
    output logic           XferRt,
    output logic           XferBm,
    output logic           Done,
    output logic           Busy,
    output logic           Err,
    output logic [2:0]     State
);

    localparam int PW = $clog2(NCH);

    hs_state_e      state_q, state_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic [NCH-1:0] tog_q, tog_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           type_bm_q, type_bm_d;
    logic           busy_q, busy_d;
    logic           to_hit;

    logic [NCH-1:0] req_vec;
    logic [NCH-1:0] rr_gnt;
    logic           rr_vld;
    logic [3:0]     gnt_idx;
    logic [PW-1:0]  ptr_adv;
    logic           sel_bm, want_rt_sel, want_bm_sel, tog_sel, held;

    always_comb begin
        case (Prog)
            PROG_RT: req_vec = WantRt;
            PROG_BM: req_vec = WantBm;
            default: req_vec = WantRt | WantBm;
        endcase
    end

    hs_rr_arb #(.NCH(NCH), .PW(PW)) u_rr (
        .req (req_vec),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .vld (rr_vld)
    );

    assign want_rt_sel = |(WantRt & rr_gnt);
    assign want_bm_sel = |(WantBm & rr_gnt);
    assign tog_sel     = |(tog_q & rr_gnt);
    assign gnt_idx     = oh2idx(16'(grant_q));
    assign ptr_adv     = (gnt_idx == 4'(NCH-1)) ? '0 : PW'(gnt_idx + 4'd1);
    assign held        = type_bm_q ? |(WantBm & grant_q) : |(WantRt & grant_q);

    // Toggle bit set means the channel was last served as a route move.
    always_comb begin
        case (Prog)
            PROG_RT:       sel_bm = 1'b0;
            PROG_BM:       sel_bm = 1'b1;
            PROG_BOTH_PRI: sel_bm = !want_rt_sel;
            default:       sel_bm = (want_rt_sel && want_bm_sel) ? tog_sel : !want_rt_sel;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tog_d     = tog_q;
        ptr_d     = ptr_q;
        type_bm_d = type_bm_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec && !FullI && !FullO) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (rr_vld) begin
                    grant_d   = rr_gnt;
                    type_bm_d = sel_bm;
                    state_d   = ST_WAIT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT1, ST_WAIT2: begin
                if (!held) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                end else if (!FullO) begin
                    if (state_q == ST_WAIT1 && |(Rdy1 & grant_q)) state_d = ST_WAIT2;
                    if (state_q == ST_WAIT2 && |(Rdy2 & grant_q)) state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                state_d = ST_DRAIN;
                tog_d   = type_bm_q ? (tog_q & ~grant_q) : (tog_q | grant_q);
            end
            ST_DRAIN: begin
                if (InDone || to_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CK or negedge RstN) begin
        if (!RstN) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            tog_q     <= '0;
            ptr_q     <= '0;
            type_bm_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tog_q     <= tog_d;
            ptr_q     <= ptr_d;
            type_bm_q <= type_bm_d;
            busy_q    <= busy_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          in_wait;

    assign in_wait = (state_q == ST_WAIT1) || (state_q == ST_WAIT2) || (state_q == ST_DRAIN);
    assign to_hit  = in_wait && (cnt_q == CW'(TO_CYC - 1));

    // A state change restarts the count, so each wait state gets its own budget.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && in_wait) cnt_d = cnt_q + 1'b1;
        err_d = err_q;
        if (state_q == ST_ARB) err_d = 1'b0;
        if (to_hit && held && !(state_q == ST_DRAIN && InDone)) err_d = 1'b1;
        if (to_hit && state_q == ST_DRAIN && !InDone) err_d = 1'b1;
    end

    always_ff @(posedge CK or negedge RstN) begin
        if (!RstN) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign to_hit = 1'b0;
    // No timeout hardware in this build; the comparison folds to constant 0.
    assign Err    = (TO_CYC < 0);
`endif

    assign Grant  = grant_q;
    assign Busy   = busy_q;
    assign State  = state_q;
    assign XferRt = (state_q == ST_XFER) && !type_bm_q;
    assign XferBm = (state_q == ST_XFER) && type_bm_q;
    assign Done   = (state_q == ST_DRAIN) && InDone;

endmodule

// File: tb/tb_hs_arb_ctrl.sv
// Directed bench for hs_arb_ctrl (NCH=4); the timeout scenario runs only when
// HS_TIMEOUT_EN is defined.
module tb_hs_arb_ctrl;

    logic       CK = 1'b0;
    logic       RstN;
    logic [3:0] WantRt, WantBm, Rdy1, Rdy2;
    logic       FullI, FullO, InDone;
    logic [1:0] Prog;
    logic [3:0] Grant;
    logic       XferRt, XferBm, Done, Busy, Err;
    logic [2:0] State;

    int tests = 0;
    int fails = 0;

    hs_arb_ctrl #(.NCH(4), .TO_CYC(16)) dut (
        .CK(CK), .RstN(RstN), .WantRt(WantRt), .WantBm(WantBm),
        .Rdy1(Rdy1), .Rdy2(Rdy2), .FullI(FullI), .FullO(FullO),
        .InDone(InDone), .Prog(Prog), .Grant(Grant), .XferRt(XferRt),
        .XferBm(XferBm), .Done(Done), .Busy(Busy), .Err(Err), .State(State)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic reset_dut();
        RstN = 1'b0; WantRt = '0; WantBm = '0; Rdy1 = 4'hF; Rdy2 = 4'hF;
        FullI = 1'b0; FullO = 1'b0; InDone = 1'b0; Prog = 2'b00;
        tick(); tick();
        RstN = 1'b1;
        tick();
    endtask

    // Runs one full transfer from IDLE with requests held, capturing observations.
    task automatic run_xfer(output logic [3:0] g, output logic xr, output logic xb, output logic dn);
        tick();                 // ARB
        tick(); g = Grant;      // WAIT1
        tick();                 // WAIT2
        tick(); xr = XferRt; xb = XferBm;
        tick();                 // DRAIN
        InDone = 1'b1; #1; dn = Done;
        tick();                 // IDLE
        InDone = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (State !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", State); end
        tests++; if (Grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", Grant); end
        tests++; if (Busy !== 1'b0 || Err !== 1'b0) begin fails++; $display("FAIL reset_busy_err got=%b%b exp=00", Busy, Err); end
        tests++; if ({XferRt, XferBm, Done} !== 3'b000) begin fails++; $display("FAIL reset_pulses got=%b exp=000", {XferRt, XferBm, Done}); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        logic [3:0] g; logic xr, xb, dn;
        reset_dut();
        WantRt = 4'b0010;
        tick();
        tests++; if (State !== 3'd1 || Busy !== 1'b1) begin fails++; $display("FAIL single_arb got state=%0d busy=%b exp=1,1", State, Busy); end
        tick();
        tests++; if (Grant !== 4'b0010 || State !== 3'd2) begin fails++; $display("FAIL single_grant got=%b/%0d exp=0010/2", Grant, State); end
        tick();
        tests++; if (XferRt !== 1'b0) begin fails++; $display("FAIL single_early_xfer got=%b exp=0", XferRt); end
        tick();
        tests++; if (XferRt !== 1'b1 || XferBm !== 1'b0 || State !== 3'd4) begin fails++; $display("FAIL single_xfer got rt=%b bm=%b st=%0d exp=1,0,4", XferRt, XferBm, State); end
        tick();
        tests++; if (State !== 3'd5 || Done !== 1'b0) begin fails++; $display("FAIL single_drain got st=%0d done=%b exp=5,0", State, Done); end
        InDone = 1'b1; WantRt = '0; #1;
        tests++; if (Done !== 1'b1) begin fails++; $display("FAIL single_done got=%b exp=1", Done); end
        tick();
        InDone = 1'b0;
        tests++; if (State !== 3'd0 || Grant !== 4'b0000 || Done !== 1'b0) begin fails++; $display("FAIL single_idle got st=%0d g=%b d=%b exp=0,0000,0", State, Grant, Done); end
        // Pointer should now be 2: with all channels requesting, channel 2 wins.
        WantRt = 4'b1111;
        run_xfer(g, xr, xb, dn);
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL single_ptr got=%b exp=0100", g); end
        $display("[TB] single transfer checked");
    endtask

    task automatic test_round_robin();
        logic [3:0] g; logic xr, xb, dn;
        logic [3:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
        reset_dut();
        WantRt = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            run_xfer(g, xr, xb, dn);
            tests++; if (g !== exp_g[i] || xr !== 1'b1 || dn !== 1'b1) begin fails++; $display("FAIL rr_%0d got g=%b rt=%b done=%b exp=%b,1,1", i, g, xr, dn, exp_g[i]); end
            $display("[TB] rr transfer %0d grant=%b", i, g);
        end
        WantRt = '0;
    endtask

    task automatic test_modes();
        logic [3:0] g; logic xr, xb, dn;
        reset_dut();
        Prog = 2'b11; WantRt = 4'b0010; WantBm = 4'b0010;
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b10 || g !== 4'b0010) begin fails++; $display("FAIL alt_first got rt/bm=%b%b g=%b exp=10,0010", xr, xb, g); end
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b01) begin fails++; $display("FAIL alt_second got rt/bm=%b%b exp=01", xr, xb); end
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b10) begin fails++; $display("FAIL alt_third got rt/bm=%b%b exp=10", xr, xb); end
        Prog = 2'b10;
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b10) begin fails++; $display("FAIL pri_both got rt/bm=%b%b exp=10", xr, xb); end
        WantRt = '0;
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b01) begin fails++; $display("FAIL pri_bm_only got rt/bm=%b%b exp=01", xr, xb); end
        // Route-only request under block-move mode is not enabled.
        WantBm = '0; WantRt = 4'b0001; Prog = 2'b01;
        tick(); tick();
        tests++; if (State !== 3'd0) begin fails++; $display("FAIL mode_mask got st=%0d exp=0", State); end
        Prog = 2'b00;
        run_xfer(g, xr, xb, dn);
        tests++; if ({xr, xb} !== 2'b10 || g !== 4'b0001) begin fails++; $display("FAIL rt_mode got rt/bm=%b%b g=%b exp=10,0001", xr, xb, g); end
        WantRt = '0;
        $display("[TB] mode selection checked");
    endtask

    task automatic test_withdraw();
        logic [3:0] g; logic xr, xb, dn;
        reset_dut();
        WantRt = 4'b0100;
        tick(); tick();
        tests++; if (State !== 3'd2 || Grant !== 4'b0100) begin fails++; $display("FAIL wd_wait1 got st=%0d g=%b exp=2,0100", State, Grant); end
        WantRt = '0;
        tick();
        tests++; if (State !== 3'd0 || Grant !== 4'b0000 || Done !== 1'b0) begin fails++; $display("FAIL wd_idle got st=%0d g=%b d=%b exp=0,0000,0", State, Grant, Done); end
        WantRt = 4'b1111;
        run_xfer(g, xr, xb, dn);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL wd_ptr got=%b exp=0001", g); end
        WantRt = '0;
        $display("[TB] withdrawal checked");
    endtask

    task automatic test_full_flags();
        reset_dut();
        FullI = 1'b1; WantRt = 4'b0001;
        tick(); tick();
        tests++; if (State !== 3'd0) begin fails++; $display("FAIL fulli_block got st=%0d exp=0", State); end
        FullI = 1'b0;
        tick();
        FullO = 1'b1;
        tick(); tick(); tick();
        tests++; if (State !== 3'd2) begin fails++; $display("FAIL fullo_hold got st=%0d exp=2", State); end
        FullO = 1'b0;
        tick();
        tests++; if (State !== 3'd3) begin fails++; $display("FAIL fullo_release got st=%0d exp=3", State); end
        Rdy2 = 4'b0000;
        tick(); tick();
        tests++; if (State !== 3'd3) begin fails++; $display("FAIL rdy2_hold got st=%0d exp=3", State); end
        WantRt = '0; Rdy2 = 4'hF;
        tick();
        $display("[TB] full flags checked");
    endtask

    task automatic test_reset_in_drain();
        reset_dut();
        WantRt = 4'b0001;
        repeat (5) tick();
        WantRt = '0;
        tests++; if (State !== 3'd5) begin fails++; $display("FAIL rd_drain got st=%0d exp=5", State); end
        #2 RstN = 1'b0;
        #1;
        tests++; if (State !== 3'd0 || Grant !== 4'b0000 || Busy !== 1'b0) begin fails++; $display("FAIL rd_async got st=%0d g=%b b=%b exp=0,0000,0", State, Grant, Busy); end
        tick();
        RstN = 1'b1; InDone = 1'b1;
        #1;
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL rd_no_done got=%b exp=0", Done); end
        tick();
        tests++; if (Done !== 1'b0 || State !== 3'd0) begin fails++; $display("FAIL rd_after got d=%b st=%0d exp=0,0", Done, State); end
        InDone = 1'b0;
        $display("[TB] reset in drain checked");
    endtask

`ifdef HS_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        Rdy1 = 4'b0000; WantRt = 4'b0011;
        tick(); tick();      // first WAIT1 cycle
        repeat (15) tick();
        tests++; if (State !== 3'd2) begin fails++; $display("FAIL to_wait got st=%0d exp=2", State); end
        tick();
        tests++; if (State !== 3'd0 || Err !== 1'b1 || Done !== 1'b0 || Grant !== 4'b0000) begin fails++; $display("FAIL to_fire got st=%0d e=%b d=%b g=%b exp=0,1,0,0000", State, Err, Done, Grant); end
        tick(); tick();
        tests++; if (Err !== 1'b0 || Grant !== 4'b0010) begin fails++; $display("FAIL to_clear got e=%b g=%b exp=0,0010", Err, Grant); end
        WantRt = '0; Rdy1 = 4'hF;
        tick();
        $display("[TB] timeout checked");
    endtask
`else
    task automatic test_no_timeout();
        reset_dut();
        Rdy1 = 4'b0000; WantRt = 4'b0001;
        repeat (30) tick();
        tests++; if (State !== 3'd2 || Err !== 1'b0) begin fails++; $display("FAIL hold_forever got st=%0d e=%b exp=2,0", State, Err); end
        WantRt = '0; Rdy1 = 4'hF;
        tick();
        $display("[TB] indefinite wait checked");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_modes();
        test_withdraw();
        test_full_flags();
        test_reset_in_drain();
`ifdef HS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
